// File: rtl/image_loader.sv
// Boot/image loader: consumes a header+data word stream and writes it into the
// instruction ROM, data SRAM or register file, then releases the core on RUN.
module image_loader #(
  parameter  int ROM_W     = 16,
  parameter  int ROM_DEPTH = 256,
  parameter  int RAM_W     = 8,
  parameter  int RAM_DEPTH = 256,
  parameter  int REG_W     = 8,
  parameter  int NREGS     = 8,
  localparam int ROM_AW    = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1,
  localparam int RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1,
  localparam int REG_AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [ROM_W-1:0]  rom_wdata,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [RAM_W-1:0]  ram_wdata,
  output logic              reg_we,
  output logic [REG_AW-1:0] reg_addr,
  output logic [REG_W-1:0]  reg_wdata,
  output logic              core_rstn,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {S_HDR, S_DATA, S_RUN} state_t;

  localparam logic [1:0]  TGT_ROM = 2'd0;
  localparam logic [1:0]  TGT_RAM = 2'd1;
  localparam logic [1:0]  TGT_REG = 2'd2;
  localparam logic [1:0]  TGT_RUN = 2'd3;
  localparam logic [16:0] ROM_LIM = 17'(ROM_DEPTH);
  localparam logic [16:0] RAM_LIM = 17'(RAM_DEPTH);
  localparam logic [16:0] REG_LIM = 17'(NREGS);

  state_t              state_q, state_d;
  logic [1:0]          tgt_q, tgt_d;
  logic [16:0]         ptr_q, ptr_d;
  logic [13:0]         rem_q, rem_d;
  logic                err_q, err_d;

  logic                rom_we_q, rom_we_d;
  logic [ROM_AW-1:0]   rom_addr_q, rom_addr_d;
  logic [ROM_W-1:0]    rom_wdata_q, rom_wdata_d;
  logic                ram_we_q, ram_we_d;
  logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
  logic [RAM_W-1:0]    ram_wdata_q, ram_wdata_d;
  logic                reg_we_q, reg_we_d;
  logic [REG_AW-1:0]   reg_addr_q, reg_addr_d;
  logic [REG_W-1:0]    reg_wdata_q, reg_wdata_d;

  logic                accept;

  assign in_ready  = ~rst & (state_q != S_RUN);
  assign accept    = in_valid & in_ready;
  assign busy      = (state_q == S_DATA);
  assign core_rstn = (state_q == S_RUN);
  assign err       = err_q;

  assign rom_we    = rom_we_q;
  assign rom_addr  = rom_addr_q;
  assign rom_wdata = rom_wdata_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    err_d       = err_q;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    reg_we_d    = 1'b0;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;

    case (state_q)
      S_HDR: begin
        if (accept) begin
          if (in_data[31:30] == TGT_RUN) begin
            state_d = S_RUN;
          end else if (in_data[29:16] != 14'd0) begin
            tgt_d   = in_data[31:30];
            ptr_d   = {1'b0, in_data[15:0]};
            rem_d   = in_data[29:16];
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          // Out-of-range beats are consumed but only raise the sticky error.
          case (tgt_q)
            TGT_ROM: begin
              if (ptr_q < ROM_LIM) begin
                rom_we_d    = 1'b1;
                rom_addr_d  = ptr_q[ROM_AW-1:0];
                rom_wdata_d = in_data[ROM_W-1:0];
              end else begin
                err_d = 1'b1;
              end
            end
            TGT_RAM: begin
              if (ptr_q < RAM_LIM) begin
                ram_we_d    = 1'b1;
                ram_addr_d  = ptr_q[RAM_AW-1:0];
                ram_wdata_d = in_data[RAM_W-1:0];
              end else begin
                err_d = 1'b1;
              end
            end
            TGT_REG: begin
              if (ptr_q < REG_LIM) begin
                reg_we_d    = 1'b1;
                reg_addr_d  = ptr_q[REG_AW-1:0];
                reg_wdata_d = in_data[REG_W-1:0];
              end else begin
                err_d = 1'b1;
              end
            end
            default: ;
          endcase
          ptr_d = ptr_q + 17'd1;
          rem_d = rem_q - 14'd1;
          if (rem_q == 14'd1) state_d = S_HDR;
        end
      end
      S_RUN:   ;
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    tgt_q <= tgt_d;
    ptr_q <= ptr_d;
    rem_q <= rem_d;
    if (rst) begin
      state_q     <= S_HDR;
      err_q       <= 1'b0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
    end
  end

endmodule

// File: doc/image_loader.md
# image_loader

Parametrised boot/image loader for the RISC core. It accepts a word stream over a valid/ready handshake and writes it into the instruction ROM, data SRAM and register file through their write ports. It holds the core in reset until a RUN command arrives, then releases it. This replaces hierarchical memory poking, so the same program image can be loaded in simulation and on hardware.

## Interface
- ROM_W, 16: instruction word width
- ROM_DEPTH, 256: ROM words; ROM_AW = $clog2(ROM_DEPTH)
- RAM_W, 8: SRAM word width
- RAM_DEPTH, 256: SRAM words; RAM_AW = $clog2(RAM_DEPTH)
- REG_W, 8: register width
- NREGS, 8: register count; REG_AW = $clog2(NREGS)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  stream word valid
- in_ready  out  1  loader accepts word
- in_data  in  32  header or data word
- rom_we / rom_addr / rom_wdata  out  1 / ROM_AW / ROM_W  ROM write port
- ram_we / ram_addr / ram_wdata  out  1 / RAM_AW / RAM_W  SRAM write port
- reg_we / reg_addr / reg_wdata  out  1 / REG_AW / REG_W  register-file write port
- core_rstn  out  1  active-low core reset, low until RUN
- busy  out  1  high while in DATA state
- err  out  1  sticky out-of-range flag

## Operation
- A beat is accepted on any clk edge where in_valid & in_ready are both high.
- Header format:
  - [31:30] target: 0 ROM, 1 RAM, 2 REG, 3 RUN
  - [29:16] count: number of data words, 0..16383
  - [15:0] base address
- FSM states: HDR, DATA, RUN.
- HDR:
  - in_ready = 1.
  - Header with target 0-2 and count > 0: latch target, set ptr = base, set remaining = count, go to DATA.
  - Header with target 0-2 and count = 0: stay in HDR; no write.
  - Header with target 3: go to RUN; count and base are ignored.
- DATA:
  - in_ready = 1 and busy = 1.
  - Each accepted beat writes in_data[W-1:0] (W = target width) to ptr.
  - After each beat: ptr += 1, remaining -= 1.
  - When remaining reaches 0, go to HDR.
- RUN:
  - in_ready = 0.
  - core_rstn = 1.
  - Terminal state; only rst leaves it.
- Address rule:
  - ptr is 17 bits and never wraps.
  - If ptr >= DEPTH (NREGS for REG), the beat is still consumed, the write is suppressed, and err is set.
  - err stays set until rst.
- Only one of rom_we, ram_we, reg_we is ever high in a given cycle.
- Existing memory contents are never cleared by the loader.
- Reset:
  - Outputs: in_ready 0, all *_we 0, all addr/wdata 0, core_rstn 0, busy 0, err 0.
  - State returns to HDR.
- Reset mid-DATA: the transfer is aborted, no further writes occur, and the partially written data remains in memory.

## Timing
- in_ready is decoded from state and forced to 0 while rst is high. It is 1 on the first cycle after rst deasserts.
- Write latency: the *_we pulse is high for exactly one cycle, on the cycle after beat acceptance, with addr/wdata registered alongside it.
- Gaps:
  - Back-to-back beats give back-to-back write pulses.
  - If in_valid drops, no write is issued and no state changes.
- The earliest RUN header is accepted one cycle after the final data beat, so the final write always completes before core_rstn rises.
- core_rstn rises on the cycle after the RUN header is accepted. in_ready falls on the same edge.
- busy falls on the edge that accepts the final data beat.
- err is set on the same edge as the suppressed beat's acceptance and is visible the following cycle.
- Throughput: one word per cycle. Header overhead is one cycle per block.

## Test plan
- ROM load: header {0, count 3, base 1}, then data 0x0111, 0x0222, 0x0333 back-to-back -> rom_we pulses on 3 consecutive cycles at addr 1/2/3 with those data; err = 0.
- RAM + REG load:
  - RAM {1, count 7, base 0} with data 0, 10, ..., 60 -> ram_we at addr 0..6 with those values.
  - REG {2, count 8, base 0} with data 1..8 -> reg_we at addr 0..7 with those values.
- Backpressure gaps: the same ROM load with in_valid toggled every other cycle -> exactly 3 writes, no duplicates, correct addresses; busy stays high until the third beat.
- Out of range: RAM {1, count 4, base 254} with RAM_DEPTH 256 -> writes at addr 254 and 255 only; err = 1 after the third beat and stays 1; state returns to HDR after the fourth beat.
- RUN: after a load, header {3, count 5, base 0} -> core_rstn = 1 and in_ready = 0 on the next cycle; later in_valid beats produce no writes.
- Reset mid-DATA: rst for one cycle after beat 2 of 5 -> no further writes; err = 0, core_rstn = 0, busy = 0; a fresh header is accepted on the first cycle after reset.
